pc_unit: RTL and testbench



---
 rtl/pc_unit.sv | 129 ++++++++++++
 tb/tb_pc_unit.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// pc_unit: program-sequencing stage that sits after the ALU.
// Holds the program counter, resolves branch-if-equal from the ALU result,
// keeps a loadable branch-target table, runs the Req/Ack start/finish
// handshake and counts the cycles spent running the program.
module pc_unit #(
    parameter int PC_W     = 10,
    parameter int LUT_AW   = 4,
    parameter int START_PC = 0,
    parameter int CNT_W    = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Req,
    output logic              Ack,
    input  logic              halt,
    input  logic              branch_en,
    input  logic [7:0]        alu_result,
    input  logic [LUT_AW-1:0] target_idx,
    input  logic              lut_we,
    input  logic [LUT_AW-1:0] lut_addr,
    input  logic [PC_W-1:0]   lut_wdata,
    output logic [PC_W-1:0]   pc,
    output logic              run,
    output logic              taken,
    output logic [CNT_W-1:0]  cycle_count
);

    localparam int LUT_DEPTH = 2 ** LUT_AW;
    localparam logic [PC_W-1:0]  START_VAL = PC_W'(START_PC);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic [PC_W-1:0]   pc_q;
    logic [PC_W-1:0]   pc_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              run_q;
    logic              ack_q;
    logic              taken_d;
    logic [PC_W-1:0]   lut_q [LUT_DEPTH];

    // Branch is taken only while running, when not halting, and the ALU says the operands were equal
    always_comb begin
        taken_d = (state_q == RUN) && branch_en && !halt && (alu_result == 8'h00);
    end

    // Next PC (table target or wrapping increment) and saturating cycle counter
    always_comb begin
        pc_d  = pc_q + PC_W'(1);
        cnt_d = cnt_q;
        if (taken_d) begin
            pc_d = lut_q[target_idx];
        end
        if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Branch-target table: cleared by reset, writable only while no program is running
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < LUT_DEPTH; i++) begin
                lut_q[i] <= '0;
            end
        end else if (lut_we && (state_q != RUN)) begin
            lut_q[lut_addr] <= lut_wdata;
        end
    end

    // Sequencing FSM with registered pc, run, Ack and cycle count
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            pc_q    <= START_VAL;
            cnt_q   <= '0;
            run_q   <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (Req) begin
                        state_q <= RUN;
                        pc_q    <= START_VAL;
                        cnt_q   <= '0;
                        run_q   <= 1'b1;
                        ack_q   <= 1'b0;
                    end
                end
                RUN: begin
                    cnt_q <= cnt_d;
                    if (halt) begin
                        state_q <= DONE;
                        run_q   <= 1'b0;
                        ack_q   <= 1'b1;
                    end else begin
                        pc_q <= pc_d;
                    end
                end
                DONE: begin
                    if (Req) begin
                        state_q <= RUN;
                        pc_q    <= START_VAL;
                        cnt_q   <= '0;
                        run_q   <= 1'b1;
                        ack_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    run_q   <= 1'b0;
                    ack_q   <= 1'b0;
                end
            endcase
        end
    end

    assign pc          = pc_q;
    assign run         = run_q;
    assign Ack         = ack_q;
    assign cycle_count = cnt_q;
    assign taken       = taken_d;

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed scenarios plus randomized traffic for pc_unit.
// Two instances run side by side on the same stimulus: the default
// configuration and a narrow one (4-bit pc, 4-bit counter) that exposes
// pc wrap-around and counter saturation quickly.
module tb_pc_unit;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DONE = 2;

    logic       Clk;
    logic       Reset;
    logic       Req;
    logic       halt;
    logic       branchEn;
    logic [7:0] aluResult;
    logic [3:0] targetIdx;
    logic       lutWe;
    logic [3:0] lutAddr;
    logic [9:0] lutWdata;

    logic        Ack;
    logic [9:0]  pc;
    logic        run;
    logic        taken;
    logic [15:0] cycleCount;

    logic        AckS;
    logic [3:0]  pcS;
    logic        runS;
    logic        takenS;
    logic [3:0]  cycleCountS;

    int nCompared;
    int nMismatched;

    // reference model state, index 0 = default instance, 1 = narrow instance
    int mState [2];
    int mPc    [2];
    int mCnt   [2];
    int mTable [2][16];

    pc_unit dut (
        .Clk(Clk), .Reset(Reset), .Req(Req), .Ack(Ack),
        .halt(halt), .branch_en(branchEn), .alu_result(aluResult),
        .target_idx(targetIdx), .lut_we(lutWe), .lut_addr(lutAddr),
        .lut_wdata(lutWdata), .pc(pc), .run(run), .taken(taken),
        .cycle_count(cycleCount)
    );

    pc_unit #(.PC_W(4), .LUT_AW(4), .START_PC(0), .CNT_W(4)) dutSmall (
        .Clk(Clk), .Reset(Reset), .Req(Req), .Ack(AckS),
        .halt(halt), .branch_en(branchEn), .alu_result(aluResult),
        .target_idx(targetIdx), .lut_we(lutWe), .lut_addr(lutAddr),
        .lut_wdata(lutWdata[3:0]), .pc(pcS), .run(runS), .taken(takenS),
        .cycle_count(cycleCountS)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic int pcMod(int k);
        return (k == 0) ? 1024 : 16;
    endfunction

    function automatic int cntMax(int k);
        return (k == 0) ? 65535 : 15;
    endfunction

    function automatic bit modelTaken(int k);
        return (mState[k] == M_RUN) && branchEn && !halt && (aluResult == 8'h00);
    endfunction

    // Apply the spec rules for one rising edge to both model copies
    task automatic modelStep();
        for (int k = 0; k < 2; k++) begin
            if (Reset) begin
                mState[k] = M_IDLE;
                mPc[k]    = 0;
                mCnt[k]   = 0;
                for (int i = 0; i < 16; i++) mTable[k][i] = 0;
            end else if (mState[k] == M_RUN) begin
                mCnt[k] = (mCnt[k] < cntMax(k)) ? mCnt[k] + 1 : mCnt[k];
                if (halt) mState[k] = M_DONE;
                else if (modelTaken(k)) mPc[k] = mTable[k][targetIdx];
                else mPc[k] = (mPc[k] + 1) % pcMod(k);
            end else begin
                if (lutWe) mTable[k][lutAddr] = int'(lutWdata) % pcMod(k);
                if (Req) begin
                    mState[k] = M_RUN;
                    mPc[k]    = 0;
                    mCnt[k]   = 0;
                end
            end
        end
    endtask

    task automatic clearInputs();
        Reset = 0; Req = 0; halt = 0; branchEn = 0; aluResult = 8'h55;
        targetIdx = 0; lutWe = 0; lutAddr = 0; lutWdata = 0;
    endtask

    // One rising edge: model follows, outputs sampled 1 time unit later
    task automatic tick();
        @(posedge Clk);
        modelStep();
        #1;
    endtask

    task automatic test_reset();
        clearInputs();
        Reset = 1;
        tick();
        tick();
        Reset = 0;
        nCompared++;
        if (pc !== 10'd0 || run !== 1'b0 || Ack !== 1'b0 || cycleCount !== 16'd0) begin
            nMismatched++;
            $display("[TB] FAIL reset_state: pc=%0d run=%b Ack=%b cnt=%0d, want 0/0/0/0", pc, run, Ack, cycleCount);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            nCompared++;
            if (pc !== 10'd0 || run !== 1'b0 || Ack !== 1'b0 || cycleCount !== 16'd0) begin
                nMismatched++;
                $display("[TB] FAIL idle_hold[%0d]: pc=%0d run=%b Ack=%b cnt=%0d, want 0/0/0/0", i, pc, run, Ack, cycleCount);
            end
        end
    endtask

    task automatic test_straight_line();
        clearInputs();
        Req = 1;
        tick();
        Req = 0;
        for (int i = 0; i < 5; i++) begin
            nCompared++;
            if (pc !== 10'(i) || run !== 1'b1 || cycleCount !== 16'(i)) begin
                nMismatched++;
                $display("[TB] FAIL straight_pc[%0d]: pc=%0d run=%b cnt=%0d, want %0d/1/%0d", i, pc, run, cycleCount, i, i);
            end
            tick();
        end
        halt = 1;
        tick();
        halt = 0;
        nCompared++;
        if (Ack !== 1'b1 || run !== 1'b0 || pc !== 10'd5 || cycleCount !== 16'd6) begin
            nMismatched++;
            $display("[TB] FAIL straight_done: Ack=%b run=%b pc=%0d cnt=%0d, want 1/0/5/6", Ack, run, pc, cycleCount);
        end
        tick();
        tick();
        nCompared++;
        if (Ack !== 1'b1 || pc !== 10'd5 || cycleCount !== 16'd6) begin
            nMismatched++;
            $display("[TB] FAIL straight_hold: Ack=%b pc=%0d cnt=%0d, want 1/5/6", Ack, pc, cycleCount);
        end
    endtask

    task automatic test_branch();
        clearInputs();
        Reset = 1;
        tick();
        Reset = 0;
        lutWe = 1; lutAddr = 4'd3; lutWdata = 10'h040;
        tick();
        lutWe = 0;
        Req = 1;
        tick();
        Req = 0;
        tick();
        tick();
        branchEn = 1; targetIdx = 4'd3; aluResult = 8'h00;
        #1;
        nCompared++;
        if (taken !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL branch_taken: taken=%b pc=%0d, want 1 at pc 2", taken, pc);
        end
        tick();
        nCompared++;
        if (pc !== 10'h040) begin
            nMismatched++;
            $display("[TB] FAIL branch_target: pc=%h, want 040", pc);
        end
        clearInputs();
        halt = 1;
        tick();
        halt = 0;
        Req = 1;
        tick();
        Req = 0;
        tick();
        tick();
        branchEn = 1; targetIdx = 4'd3; aluResult = 8'h01;
        #1;
        nCompared++;
        if (taken !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL branch_not_taken: taken=%b, want 0", taken);
        end
        tick();
        nCompared++;
        if (pc !== 10'd3) begin
            nMismatched++;
            $display("[TB] FAIL branch_fallthrough: pc=%0d, want 3", pc);
        end
        clearInputs();
    endtask

    task automatic test_priority();
        clearInputs();
        halt = 1; branchEn = 1; aluResult = 8'h00; targetIdx = 4'd3; Req = 1;
        #1;
        nCompared++;
        if (taken !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL halt_beats_branch_taken: taken=%b, want 0", taken);
        end
        tick();
        clearInputs();
        nCompared++;
        if (Ack !== 1'b1 || run !== 1'b0 || pc !== 10'd3) begin
            nMismatched++;
            $display("[TB] FAIL halt_beats_branch: Ack=%b run=%b pc=%0d, want 1/0/3", Ack, run, pc);
        end
        Req = 1;
        tick();
        Req = 0;
        lutWe = 1; lutAddr = 4'd3; lutWdata = 10'h100;
        tick();
        lutWe = 0;
        branchEn = 1; targetIdx = 4'd3; aluResult = 8'h00;
        tick();
        nCompared++;
        if (pc !== 10'h040) begin
            nMismatched++;
            $display("[TB] FAIL run_write_ignored: pc=%h, want 040", pc);
        end
        clearInputs();
        halt = 1;
        tick();
        halt = 0;
    endtask

    task automatic test_wrap_saturate();
        clearInputs();
        Req = 1;
        tick();
        Req = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            nCompared++;
            if (pcS !== 4'(i % 16) || cycleCountS !== 4'((i < 15) ? i : 15)) begin
                nMismatched++;
                $display("[TB] FAIL wrap_sat[%0d]: pc=%0d cnt=%0d, want %0d/%0d", i, pcS, cycleCountS, i % 16, (i < 15) ? i : 15);
            end
            nCompared++;
            if (pc !== 10'(i) || cycleCount !== 16'(i)) begin
                nMismatched++;
                $display("[TB] FAIL wide_count[%0d]: pc=%0d cnt=%0d, want %0d/%0d", i, pc, cycleCount, i, i);
            end
        end
        halt = 1;
        tick();
        halt = 0;
    endtask

    task automatic test_reset_mid_run();
        clearInputs();
        Req = 1;
        tick();
        Req = 0;
        for (int i = 0; i < 7; i++) tick();
        Reset = 1;
        tick();
        Reset = 0;
        nCompared++;
        if (pc !== 10'd0 || run !== 1'b0 || Ack !== 1'b0 || cycleCount !== 16'd0) begin
            nMismatched++;
            $display("[TB] FAIL reset_mid_run: pc=%0d run=%b Ack=%b cnt=%0d, want 0/0/0/0", pc, run, Ack, cycleCount);
        end
        Req = 1;
        tick();
        Req = 0;
        branchEn = 1; targetIdx = 4'd3; aluResult = 8'h00;
        tick();
        nCompared++;
        if (pc !== 10'd0) begin
            nMismatched++;
            $display("[TB] FAIL table_cleared: pc=%h, want 000", pc);
        end
        clearInputs();
        tick();
        halt = 1;
        tick();
        halt = 0;
        Req = 1;
        tick();
        Req = 0;
        nCompared++;
        if (Ack !== 1'b0 || run !== 1'b1 || pc !== 10'd0 || cycleCount !== 16'd0) begin
            nMismatched++;
            $display("[TB] FAIL restart_from_done: Ack=%b run=%b pc=%0d cnt=%0d, want 0/1/0/0", Ack, run, pc, cycleCount);
        end
    endtask

    task automatic test_random();
        logic [9:0]  obsPc  [2];
        logic [15:0] obsCnt [2];
        logic        obsRun [2];
        logic        obsAck [2];
        logic        obsTkn [2];
        clearInputs();
        for (int n = 0; n < 600; n++) begin
            Reset     = ($urandom_range(63) == 0);
            Req       = ($urandom_range(7) == 0);
            halt      = ($urandom_range(15) == 0);
            branchEn  = ($urandom_range(2) == 0);
            aluResult = $urandom_range(1) ? 8'h00 : 8'($urandom_range(255));
            targetIdx = 4'($urandom_range(15));
            lutWe     = ($urandom_range(3) == 0);
            lutAddr   = 4'($urandom_range(15));
            lutWdata  = 10'($urandom_range(1023));
            #1;
            obsTkn[0] = taken;
            obsTkn[1] = takenS;
            for (int k = 0; k < 2; k++) begin
                nCompared++;
                if (obsTkn[k] !== modelTaken(k)) begin
                    nMismatched++;
                    $display("[TB] FAIL rand_taken[%0d] inst %0d: got %b, want %b", n, k, obsTkn[k], modelTaken(k));
                end
            end
            tick();
            obsPc[0] = pc;          obsPc[1] = {6'b0, pcS};
            obsCnt[0] = cycleCount; obsCnt[1] = {12'b0, cycleCountS};
            obsRun[0] = run;        obsRun[1] = runS;
            obsAck[0] = Ack;        obsAck[1] = AckS;
            for (int k = 0; k < 2; k++) begin
                nCompared++;
                if (obsPc[k] !== 10'(mPc[k]) || obsCnt[k] !== 16'(mCnt[k]) ||
                    obsRun[k] !== (mState[k] == M_RUN) || obsAck[k] !== (mState[k] == M_DONE)) begin
                    nMismatched++;
                    $display("[TB] FAIL rand_state[%0d] inst %0d: pc=%0d cnt=%0d run=%b Ack=%b, want %0d/%0d/%b/%b",
                             n, k, obsPc[k], obsCnt[k], obsRun[k], obsAck[k],
                             mPc[k], mCnt[k], mState[k] == M_RUN, mState[k] == M_DONE);
                end
            end
        end
        clearInputs();
    endtask

    initial begin
        nCompared   = 0;
        nMismatched = 0;
        for (int k = 0; k < 2; k++) begin
            mState[k] = M_IDLE;
            mPc[k]    = 0;
            mCnt[k]   = 0;
            for (int i = 0; i < 16; i++) mTable[k][i] = 0;
        end
        clearInputs();
        @(negedge Clk);
        test_reset();
        test_straight_line();
        test_branch();
        test_priority();
        test_wrap_saturate();
        test_reset_mid_run();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
